// File: rtl/fetch_unit_pkg.sv
// Shared constants for the TSC instruction-fetch stage.
package fetch_unit_pkg;

  // Unused R-type function code; the decoder treats it as "do nothing".
  localparam logic [15:0] INST_NOP = 16'hF01F;

  typedef enum logic [1:0] {
    FETCH_FETCH = 2'd0,
    FETCH_HOLD  = 2'd1,
    FETCH_ABORT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_btb.sv
// Direct-mapped branch target buffer with one combinational lookup port
// and one synchronous update port (lookup sees the pre-update entry).
module fetch_unit_btb
  import fetch_unit_pkg::*;
#(
  parameter int BTB_IDX_W = 4,
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] lookup_pc,
  output logic                 hit,
  output logic [WORD_SIZE-1:0] target,
  input  logic                 update,
  input  logic [WORD_SIZE-1:0] update_pc,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic                 update_taken
);

  localparam int ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W   = WORD_SIZE - BTB_IDX_W;

  logic [ENTRIES-1:0]   valid;
  logic [TAG_W-1:0]     tags    [ENTRIES];
  logic [WORD_SIZE-1:0] targets [ENTRIES];

  logic [BTB_IDX_W-1:0] lookup_idx, update_idx;
  logic [TAG_W-1:0]     lookup_tag, update_tag;

  assign lookup_idx = lookup_pc[BTB_IDX_W-1:0];
  assign lookup_tag = lookup_pc[WORD_SIZE-1:BTB_IDX_W];
  assign update_idx = update_pc[BTB_IDX_W-1:0];
  assign update_tag = update_pc[WORD_SIZE-1:BTB_IDX_W];

  // Lookup: hit needs a valid entry whose tag matches the fetch PC.
  always_comb begin
    hit    = valid[lookup_idx] && (tags[lookup_idx] == lookup_tag);
    target = targets[lookup_idx];
  end

  // Valid bits: install on taken, invalidate only when the tag matches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (update) begin
      if (update_taken) begin
        valid[update_idx] <= 1'b1;
      end else if (tags[update_idx] == update_tag) begin
        valid[update_idx] <= 1'b0;
      end
    end
  end

  // Tag/target payload: qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (update && update_taken) begin
      tags[update_idx]    <= update_tag;
      targets[update_idx] <= update_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, instruction-memory handshake, BTB next-PC prediction,
// a one-word fetch buffer for stalls, and the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   WORD_SIZE = 16,
  parameter int                   BTB_IDX_W = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_write,
  input  logic                 ir_write,
  input  logic                 flush_if,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 btb_update,
  input  logic [WORD_SIZE-1:0] btb_update_pc,
  input  logic [WORD_SIZE-1:0] btb_update_target,
  input  logic                 btb_update_taken,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] ir_id,
  output logic [WORD_SIZE-1:0] pc_id,
  output logic [WORD_SIZE-1:0] pred_pc_id,
  output logic                 valid_id,
  output logic                 fetch_busy
);

  localparam logic [WORD_SIZE-1:0] ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  fetch_state_t         state;
  logic [WORD_SIZE-1:0] pc, next_pc, btb_target;
  logic [WORD_SIZE-1:0] buf_data, buf_next;
  logic [WORD_SIZE-1:0] load_data, load_next;
  logic                 btb_hit, advance, redirect, ir_load;

  fetch_unit_btb #(
    .BTB_IDX_W (BTB_IDX_W),
    .WORD_SIZE (WORD_SIZE)
  ) u_btb (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (pc),
    .hit           (btb_hit),
    .target        (btb_target),
    .update        (btb_update),
    .update_pc     (btb_update_pc),
    .update_target (btb_update_target),
    .update_taken  (btb_update_taken)
  );

  assign next_pc    = btb_hit ? btb_target : pc + ONE;
  assign advance    = ir_write & pc_write;
  assign redirect   = redirect_valid & pc_write;
  assign i_address  = pc;
  // Reset kills the request asynchronously, even though reset state is FETCH.
  assign i_readM    = (state == FETCH_FETCH) && !reset;
  assign fetch_busy = ((state == FETCH_FETCH) && !i_ready) || (state == FETCH_ABORT);

  // Choose what (if anything) enters IF/ID: the live memory word or the buffer.
  always_comb begin
    ir_load   = 1'b0;
    load_data = i_data;
    load_next = next_pc;
    case (state)
      FETCH_FETCH: ir_load = !redirect && i_ready && advance;
      FETCH_HOLD: begin
        ir_load   = !redirect && advance;
        load_data = buf_data;
        load_next = buf_next;
      end
      default: ir_load = 1'b0;
    endcase
  end

  // Fetch FSM and PC; a redirect wins over any advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH_FETCH;
      pc    <= RESET_PC;
    end else begin
      case (state)
        FETCH_FETCH: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= i_ready ? FETCH_FETCH : FETCH_ABORT;
          end else if (i_ready) begin
            if (advance) pc <= next_pc;
            else         state <= FETCH_HOLD;
          end
        end
        FETCH_HOLD: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= FETCH_FETCH;
          end else if (advance) begin
            pc    <= buf_next;
            state <= FETCH_FETCH;
          end
        end
        FETCH_ABORT: begin
          if (redirect) pc <= redirect_pc;
          state <= FETCH_FETCH;
        end
        default: state <= FETCH_FETCH;
      endcase
    end
  end

  // Fetch buffer: capture the returned word and its prediction when IF/ID is stalled.
  always_ff @(posedge clk) begin
    if ((state == FETCH_FETCH) && i_ready && !redirect && !advance) begin
      buf_data <= i_data;
      buf_next <= next_pc;
    end
  end

  // IF/ID register; flush overrides a load on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_id      <= INST_NOP;
      pc_id      <= '0;
      pred_pc_id <= '0;
      valid_id   <= 1'b0;
    end else if (flush_if) begin
      ir_id    <= INST_NOP;
      valid_id <= 1'b0;
    end else if (ir_load) begin
      ir_id      <= load_data;
      pc_id      <= pc;
      pred_pc_id <= load_next;
      valid_id   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic,
// all checked against a behavioural model of the IF stage.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, ir_write, flush_if, redirect_valid;
  logic [15:0] redirect_pc;
  logic        btb_update, btb_update_taken;
  logic [15:0] btb_update_pc, btb_update_target;
  logic        i_readM, i_ready;
  logic [15:0] i_address, i_data;
  logic [15:0] ir_id, pc_id, pred_pc_id;
  logic        valid_id, fetch_busy;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.WORD_SIZE(16), .BTB_IDX_W(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .ir_write(ir_write),
    .flush_if(flush_if), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .btb_update(btb_update), .btb_update_pc(btb_update_pc),
    .btb_update_target(btb_update_target), .btb_update_taken(btb_update_taken),
    .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
    .ir_id(ir_id), .pc_id(pc_id), .pred_pc_id(pred_pc_id), .valid_id(valid_id),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  // Reference model: program counter, the word (if any) parked waiting for
  // IF/ID, whether the cycle after a stalled redirect is dead, and the BTB
  // as a plain table of {valid, tag, target} per index.
  logic [15:0] m_pc, m_ir, m_pcid, m_pred, h_data, h_next;
  bit          m_valid, m_hold, m_abort;
  bit          bv [16];
  logic [15:0] btag [16];
  logic [15:0] btgt [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] memword(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'hF01C;
  endfunction

  function automatic logic [15:0] predict(input logic [15:0] a);
    int i;
    logic [15:0] inc;
    i = int'(a % 16);
    inc = a + 16'd1;
    if (bv[i] && btag[i] == a / 16) return btgt[i];
    return inc;
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_ir = INST_NOP; m_pcid = 0; m_pred = 0;
    m_valid = 0; m_hold = 0; m_abort = 0;
    for (int i = 0; i < 16; i++) bv[i] = 0;
  endtask

  // Drive one cycle of stimulus; memory answers only an active request.
  task automatic set_ctl(input bit rdy, input bit irw, input bit pcw, input bit fl,
                         input bit rv, input logic [15:0] rpc);
    ir_write = irw; pc_write = pcw; flush_if = fl;
    redirect_valid = rv; redirect_pc = rpc;
    btb_update = 0; btb_update_pc = 0; btb_update_target = 0; btb_update_taken = 0;
    i_ready = rdy && i_readM;
    i_data  = i_ready ? memword(i_address) : 16'hDEAD;
  endtask

  task automatic set_btb(input logic [15:0] pc, input logic [15:0] tgt, input bit taken);
    btb_update = 1; btb_update_pc = pc; btb_update_target = tgt; btb_update_taken = taken;
  endtask

  // Advance one clock, apply the rules to the model, compare every output.
  task automatic step();
    logic [15:0] nxt, ld_d, ld_n, ld_p;
    bit adv, red, ld;
    int idx;
    #1;
    chk("fetch_busy", fetch_busy, (!m_hold && !m_abort && !i_ready) || m_abort);
    @(posedge clk);
    #1;
    nxt = predict(m_pc);
    adv = ir_write && pc_write;
    red = redirect_valid && pc_write;
    ld = 0; ld_d = 0; ld_n = 0; ld_p = m_pc;
    if (m_abort) begin
      m_abort = 0;
      if (red) m_pc = redirect_pc;
    end else if (m_hold) begin
      if (red) begin
        m_pc = redirect_pc; m_hold = 0;
      end else if (adv) begin
        ld = 1; ld_d = h_data; ld_n = h_next; m_pc = h_next; m_hold = 0;
      end
    end else if (red) begin
      m_pc = redirect_pc; m_abort = !i_ready;
    end else if (i_ready) begin
      if (adv) begin
        ld = 1; ld_d = i_data; ld_n = nxt; m_pc = nxt;
      end else begin
        m_hold = 1; h_data = i_data; h_next = nxt;
      end
    end
    if (flush_if) begin
      m_ir = INST_NOP; m_valid = 0;
    end else if (ld) begin
      m_ir = ld_d; m_pcid = ld_p; m_pred = ld_n; m_valid = 1;
    end
    if (btb_update) begin
      idx = int'(btb_update_pc % 16);
      if (btb_update_taken) begin
        bv[idx] = 1; btag[idx] = btb_update_pc / 16; btgt[idx] = btb_update_target;
      end else if (bv[idx] && btag[idx] == btb_update_pc / 16) begin
        bv[idx] = 0;
      end
    end
    chk("ir_id", ir_id, m_ir);
    chk("pc_id", pc_id, m_pcid);
    chk("pred_pc_id", pred_pc_id, m_pred);
    chk("valid_id", valid_id, m_valid);
    chk("i_readM", i_readM, !m_hold && !m_abort);
    chk("i_address", i_address, m_pc);
  endtask

  task automatic do_reset();
    #2;
    reset = 1;
    #1;
    chk("rst_readM_low", i_readM, 0);
    chk("rst_pc", i_address, 16'h0000);
    chk("rst_ir", ir_id, INST_NOP);
    chk("rst_valid", valid_id, 0);
    chk("rst_pc_id", pc_id, 0);
    chk("rst_pred", pred_pc_id, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    #1;
    chk("rst_readM_release", i_readM, 1);
  endtask

  logic [15:0] rpc, bpc;

  initial begin
    reset = 1;
    pc_write = 0; ir_write = 0; flush_if = 0; redirect_valid = 0; redirect_pc = 0;
    btb_update = 0; btb_update_pc = 0; btb_update_target = 0; btb_update_taken = 0;
    i_ready = 0; i_data = 0;
    model_reset();
    do_reset();

    // 1: word from address 0 arrives after two wait cycles
    set_ctl(0, 1, 1, 0, 0, 0); step();
    set_ctl(0, 1, 1, 0, 0, 0); step();
    set_ctl(1, 1, 1, 0, 0, 0); step();
    chk("t1_ir", ir_id, 16'hF01C);
    chk("t1_pc_id", pc_id, 16'h0000);
    chk("t1_valid", valid_id, 1);
    chk("t1_next_addr", i_address, 16'h0001);

    // 2: stalled IF/ID parks the word, request is not repeated
    set_ctl(1, 0, 0, 0, 0, 0); step();
    chk("t2_readM_hold", i_readM, 0);
    set_ctl(1, 0, 0, 0, 0, 0); step();
    set_ctl(1, 0, 0, 0, 0, 0); step();
    chk("t2_ir_unchanged", ir_id, 16'hF01C);
    set_ctl(0, 1, 1, 0, 0, 0); step();
    chk("t2_ir_released", ir_id, memword(16'h0001));
    chk("t2_pc_after", i_address, 16'h0002);

    // 3: BTB hit at 0x0005 predicts 0x0020
    set_ctl(0, 1, 1, 0, 1, 16'h0005); set_btb(16'h0005, 16'h0020, 1); step();
    chk("t3_abort_readM", i_readM, 0);
    set_ctl(1, 1, 1, 0, 0, 0); step();
    set_ctl(1, 1, 1, 0, 0, 0); step();
    chk("t3_pred", pred_pc_id, 16'h0020);
    chk("t3_next_addr", i_address, 16'h0020);

    // 4: flush plus redirect with a request pending
    set_ctl(0, 1, 1, 1, 1, 16'h0040); step();
    chk("t4_valid", valid_id, 0);
    chk("t4_abort_readM", i_readM, 0);
    set_ctl(0, 1, 1, 0, 0, 0); step();
    chk("t4_refetch_readM", i_readM, 1);
    chk("t4_refetch_addr", i_address, 16'h0040);

    // 5: PC wraps from 0xFFFF to 0x0000
    set_ctl(0, 1, 1, 0, 1, 16'hFFFF); step();
    set_ctl(0, 1, 1, 0, 0, 0); step();
    set_ctl(1, 1, 1, 0, 0, 0); step();
    chk("t5_wrap_addr", i_address, 16'h0000);
    chk("t5_wrap_pred", pred_pc_id, 16'h0000);

    // 6a: invalidate with matching tag falls back to PC+1
    set_ctl(0, 1, 1, 0, 1, 16'h0005); set_btb(16'h0005, 16'h0000, 0); step();
    set_ctl(0, 1, 1, 0, 0, 0); step();
    set_ctl(1, 1, 1, 0, 0, 0); step();
    chk("t6_invalidated", pred_pc_id, 16'h0006);
    // 6b: same-cycle install and lookup sees the old entry, later lookup the new
    set_ctl(0, 1, 1, 0, 1, 16'h0005); step();
    set_ctl(0, 1, 1, 0, 0, 0); step();
    set_ctl(1, 1, 1, 0, 0, 0); set_btb(16'h0005, 16'h0030, 1); step();
    chk("t6_read_before_write", pred_pc_id, 16'h0006);
    set_ctl(0, 1, 1, 0, 1, 16'h0005); step();
    set_ctl(0, 1, 1, 0, 0, 0); step();
    set_ctl(1, 1, 1, 0, 0, 0); step();
    chk("t6_new_entry", pred_pc_id, 16'h0030);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rpc = ($urandom_range(0, 7) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                        : 16'($urandom_range(0, 47));
      bpc = ($urandom_range(0, 7) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                        : 16'($urandom_range(0, 47));
      set_ctl($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 11) == 0, rpc);
      if ($urandom_range(0, 4) == 0)
        set_btb(bpc, 16'($urandom_range(0, 47)), $urandom_range(0, 2) != 0);
      step();
    end

    // reset in the middle of an outstanding request
    set_ctl(0, 1, 1, 0, 0, 0); step();
    do_reset();
    set_ctl(1, 1, 1, 0, 0, 0); step();
    chk("post_reset_ir", ir_id, memword(16'h0000));
    set_ctl(1, 1, 1, 0, 0, 0); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
